// File: rtl/bt_exmem_arb_pkg.sv
// Shared types and constants for the BR/EDR external-memory arbiter.
// Holds the FSM state encoding, the grant ids and the default widths.
package bt_exmem_arb_pkg;

  localparam int ADR_W_DEF = 23;
  localparam int DAT_W_DEF = 32;
  localparam int TMO_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_st_e;

  localparam logic GNT_BREDR = 1'b0;
  localparam logic GNT_PCM   = 1'b1;

endpackage

// File: rtl/bt_exmem_arb_wdog.sv
// Transfer watchdog: counts BUSY cycles while enabled.
// Flags when the count reaches the configured limit.
module bt_exmem_arb_wdog
  import bt_exmem_arb_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             bsb_clk,
  input  logic             bsb_rst,
  input  logic             clr,
  input  logic             busy,
  input  logic             en,
  input  logic [TMO_W-1:0] cyc,
  output logic             hit
);

  logic [TMO_W-1:0] tmo_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge bsb_clk) begin
    if (bsb_rst || clr) begin
      tmo_cnt <= '0;
    end else if (busy && en && (tmo_cnt != '1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Disabling the watchdog freezes the count and suppresses the compare.
  assign hit = busy && en && (tmo_cnt == cyc);

endmodule

// File: rtl/bt_exmem_arb.sv
// Arbitrates the baseband exmem requester and the PCM DMA onto one exmem port.
// Fixed PCM priority with a baseband starvation limiter and a transfer watchdog.
module bt_exmem_arb
  import bt_exmem_arb_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter int TMO_W = TMO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             bsb_clk,
  input  logic             bsb_rst,
  input  logic             bredr_em_req,
  input  logic [3:0]       bredr_em_we,
  input  logic [ADR_W-1:0] bredr_em_adr,
  input  logic [DAT_W-1:0] bredr_em_wdat,
  output logic [DAT_W-1:0] bredr_em_rdat,
  output logic             bredr_em_ack,
  input  logic             pcm_dma_req,
  input  logic [3:0]       pcm_dma_we,
  input  logic [ADR_W-1:0] pcm_dma_adr,
  input  logic [DAT_W-1:0] pcm_dma_wdat,
  output logic [DAT_W-1:0] pcm_dma_rdat,
  output logic             pcm_dma_ack,
  output logic             exmem_req,
  output logic [3:0]       exmem_we,
  output logic [ADR_W-1:0] exmem_adr,
  output logic [DAT_W-1:0] exmem_wdat,
  input  logic [DAT_W-1:0] exmem_rdat,
  input  logic             exmem_ack,
  input  logic [CNT_W-1:0] cfg_pcm_max,
  input  logic             cfg_tmo_en,
  input  logic [TMO_W-1:0] cfg_tmo_cyc,
  output logic             tmo_err,
  output logic             tmo_src
);

  arb_st_e          state, state_nxt;
  logic             gnt;
  logic [CNT_W-1:0] pcm_cnt;
  logic             gnt_pcm, gnt_bredr, fin_ok, fin_tmo, tmo_hit;

  bt_exmem_arb_wdog #(.TMO_W(TMO_W)) u_wdog (
    .bsb_clk (bsb_clk),
    .bsb_rst (bsb_rst),
    .clr     (gnt_pcm || gnt_bredr),
    .busy    (state == BUSY),
    .en      (cfg_tmo_en),
    .cyc     (cfg_tmo_cyc),
    .hit     (tmo_hit)
  );

  always_ff @(posedge bsb_clk) begin
    if (bsb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    gnt_pcm   = 1'b0;
    gnt_bredr = 1'b0;
    fin_ok    = 1'b0;
    fin_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (pcm_dma_req && (!bredr_em_req || (cfg_pcm_max == '0) ||
                            (pcm_cnt < cfg_pcm_max))) begin
          gnt_pcm   = 1'b1;
          state_nxt = BUSY;
        end else if (bredr_em_req) begin
          gnt_bredr = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A real completion beats a timeout landing in the same cycle.
        if (exmem_ack) begin
          fin_ok    = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          fin_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bsb_clk) begin
    if (bsb_rst) begin
      gnt           <= GNT_BREDR;
      pcm_cnt       <= '0;
      exmem_req     <= 1'b0;
      exmem_we      <= '0;
      exmem_adr     <= '0;
      exmem_wdat    <= '0;
      bredr_em_ack  <= 1'b0;
      bredr_em_rdat <= '0;
      pcm_dma_ack   <= 1'b0;
      pcm_dma_rdat  <= '0;
      tmo_err       <= 1'b0;
      tmo_src       <= 1'b0;
    end else begin
      // Acks, read data and the error flag are single-cycle pulses.
      bredr_em_ack  <= 1'b0;
      bredr_em_rdat <= '0;
      pcm_dma_ack   <= 1'b0;
      pcm_dma_rdat  <= '0;
      tmo_err       <= 1'b0;

      if (gnt_pcm) begin
        gnt        <= GNT_PCM;
        exmem_req  <= 1'b1;
        exmem_we   <= pcm_dma_we;
        exmem_adr  <= pcm_dma_adr;
        exmem_wdat <= pcm_dma_wdat;
        if (!bredr_em_req)        pcm_cnt <= '0;
        else if (pcm_cnt != '1)   pcm_cnt <= pcm_cnt + 1'b1;
      end else if (gnt_bredr) begin
        gnt        <= GNT_BREDR;
        exmem_req  <= 1'b1;
        exmem_we   <= bredr_em_we;
        exmem_adr  <= bredr_em_adr;
        exmem_wdat <= bredr_em_wdat;
        pcm_cnt    <= '0;
      end

      if (fin_ok || fin_tmo) begin
        exmem_req <= 1'b0;
        if (gnt == GNT_PCM) begin
          pcm_dma_ack  <= 1'b1;
          pcm_dma_rdat <= fin_ok ? exmem_rdat : '0;
        end else begin
          bredr_em_ack  <= 1'b1;
          bredr_em_rdat <= fin_ok ? exmem_rdat : '0;
        end
      end

      if (fin_tmo) begin
        tmo_err <= 1'b1;
        tmo_src <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_bt_exmem_arb.sv
// Directed bench for bt_exmem_arb: read path, grant ordering, strict priority,
// watchdog timeout, ack/timeout collision and reset mid-transfer.
module tb_bt_exmem_arb;

  localparam int ADR_W = 23;
  localparam int DAT_W = 32;
  localparam int TMO_W = 8;
  localparam int CNT_W = 4;

  logic             bsb_clk = 1'b0;
  logic             bsb_rst;
  logic             bredr_em_req, pcm_dma_req;
  logic [3:0]       bredr_em_we, pcm_dma_we;
  logic [ADR_W-1:0] bredr_em_adr, pcm_dma_adr;
  logic [DAT_W-1:0] bredr_em_wdat, pcm_dma_wdat;
  logic [DAT_W-1:0] bredr_em_rdat, pcm_dma_rdat;
  logic             bredr_em_ack, pcm_dma_ack;
  logic             exmem_req;
  logic [3:0]       exmem_we;
  logic [ADR_W-1:0] exmem_adr;
  logic [DAT_W-1:0] exmem_wdat, exmem_rdat;
  logic             exmem_ack;
  logic [CNT_W-1:0] cfg_pcm_max;
  logic             cfg_tmo_en;
  logic [TMO_W-1:0] cfg_tmo_cyc;
  logic             tmo_err, tmo_src;

  int checks   = 0;
  int failures = 0;

  bt_exmem_arb #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .bsb_clk       (bsb_clk),
    .bsb_rst       (bsb_rst),
    .bredr_em_req  (bredr_em_req),
    .bredr_em_we   (bredr_em_we),
    .bredr_em_adr  (bredr_em_adr),
    .bredr_em_wdat (bredr_em_wdat),
    .bredr_em_rdat (bredr_em_rdat),
    .bredr_em_ack  (bredr_em_ack),
    .pcm_dma_req   (pcm_dma_req),
    .pcm_dma_we    (pcm_dma_we),
    .pcm_dma_adr   (pcm_dma_adr),
    .pcm_dma_wdat  (pcm_dma_wdat),
    .pcm_dma_rdat  (pcm_dma_rdat),
    .pcm_dma_ack   (pcm_dma_ack),
    .exmem_req     (exmem_req),
    .exmem_we      (exmem_we),
    .exmem_adr     (exmem_adr),
    .exmem_wdat    (exmem_wdat),
    .exmem_rdat    (exmem_rdat),
    .exmem_ack     (exmem_ack),
    .cfg_pcm_max   (cfg_pcm_max),
    .cfg_tmo_en    (cfg_tmo_en),
    .cfg_tmo_cyc   (cfg_tmo_cyc),
    .tmo_err       (tmo_err),
    .tmo_src       (tmo_src)
  );

  always #5 bsb_clk = ~bsb_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge bsb_clk);
  endtask

  // Memory model: waits for exmem_req, acks after lat BUSY cycles, returns on
  // the DONE cycle with the id of whichever requester was acked.
  task automatic mem_txn(input int lat, input logic [31:0] data,
                         output int who, output logic [31:0] rd);
    int n;
    n   = 0;
    who = -1;
    rd  = '0;
    while (!exmem_req && n < 50) begin
      tick();
      n++;
    end
    if (!exmem_req) begin
      check("req_wait", exmem_req, 1'b1);
      return;
    end
    repeat (lat - 1) tick();
    exmem_ack  = 1'b1;
    exmem_rdat = data;
    tick();
    exmem_ack  = 1'b0;
    exmem_rdat = '0;
    if (pcm_dma_ack && !bredr_em_ack) begin
      who = 1;
      rd  = pcm_dma_rdat;
    end else if (bredr_em_ack && !pcm_dma_ack) begin
      who = 0;
      rd  = bredr_em_rdat;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int          who, pulses;
    logic [31:0] rd;
    int          exp_order [6] = '{1, 1, 0, 1, 1, 0};

    bsb_rst       = 1'b1;
    bredr_em_req  = 1'b0;
    bredr_em_we   = '0;
    bredr_em_adr  = '0;
    bredr_em_wdat = '0;
    pcm_dma_req   = 1'b0;
    pcm_dma_we    = '0;
    pcm_dma_adr   = '0;
    pcm_dma_wdat  = '0;
    exmem_rdat    = '0;
    exmem_ack     = 1'b0;
    cfg_pcm_max   = '0;
    cfg_tmo_en    = 1'b0;
    cfg_tmo_cyc   = '0;
    repeat (2) tick();
    check("rst_exmem_req", exmem_req, 1'b0);
    check("rst_acks", {bredr_em_ack, pcm_dma_ack, tmo_err, tmo_src}, 4'b0000);
    check("rst_rdat", {bredr_em_rdat, pcm_dma_rdat}, 64'h0);
    bsb_rst = 1'b0;
    tick();

    // Spurious exmem_ack in IDLE is ignored.
    exmem_ack = 1'b1;
    tick();
    exmem_ack = 1'b0;
    tick();
    check("spurious_ack", {exmem_req, bredr_em_ack, pcm_dma_ack}, 3'b000);

    // Single baseband read, exmem ack three cycles after the request.
    bredr_em_req = 1'b1;
    bredr_em_adr = 23'h000100;
    tick();
    check("rd_exmem_req", exmem_req, 1'b1);
    check("rd_exmem_adr", exmem_adr, 23'h000100);
    check("rd_exmem_we", exmem_we, 4'h0);
    repeat (2) tick();
    exmem_ack  = 1'b1;
    exmem_rdat = 32'hDEADBEEF;
    tick();
    exmem_ack  = 1'b0;
    exmem_rdat = '0;
    check("rd_ack", {bredr_em_ack, pcm_dma_ack, exmem_req}, 3'b100);
    check("rd_rdat", bredr_em_rdat, 32'hDEADBEEF);
    bredr_em_req = 1'b0;
    tick();
    check("rd_ack_clr", {bredr_em_ack, bredr_em_rdat}, 33'h0);

    // Both requesting back-to-back with a limit of two PCM grants.
    cfg_pcm_max   = 4'd2;
    pcm_dma_adr   = 23'h400000;
    pcm_dma_req   = 1'b1;
    bredr_em_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_txn(1, 32'h1000 + i, who, rd);
      check($sformatf("order_%0d", i), who, exp_order[i]);
      check($sformatf("order_rdat_%0d", i), rd, 32'h1000 + i);
      tick();
    end

    // Strict priority: baseband waits until PCM stops requesting.
    cfg_pcm_max = 4'd0;
    for (int i = 0; i < 5; i++) begin
      mem_txn(1, 32'h2000 + i, who, rd);
      check($sformatf("strict_pcm_%0d", i), who, 1);
      if (i == 4) pcm_dma_req = 1'b0;
      tick();
    end
    mem_txn(2, 32'h3000, who, rd);
    check("strict_bredr", who, 0);
    bredr_em_req = 1'b0;
    tick();

    // PCM write with no exmem ack: watchdog fires after limit+1 BUSY cycles.
    cfg_tmo_en   = 1'b1;
    cfg_tmo_cyc  = 8'd10;
    pcm_dma_req  = 1'b1;
    pcm_dma_we   = 4'hF;
    pcm_dma_adr  = 23'h000200;
    pcm_dma_wdat = 32'h12345678;
    exmem_rdat   = 32'hA5A5A5A5;
    pulses       = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      pulses += int'(tmo_err);
      if (k == 1) check("tmo_exmem_cmd", {exmem_we, exmem_adr, exmem_wdat},
                        {4'hF, 23'h000200, 32'h12345678});
    end
    check("tmo_busy_at_limit", exmem_req, 1'b1);
    tick();
    pulses += int'(tmo_err);
    check("tmo_err", tmo_err, 1'b1);
    check("tmo_ack", {pcm_dma_ack, bredr_em_ack, exmem_req}, 3'b100);
    check("tmo_rdat", pcm_dma_rdat, 32'h0);
    check("tmo_src_pcm", tmo_src, 1'b1);
    pcm_dma_req = 1'b0;
    exmem_rdat  = '0;
    repeat (3) begin
      tick();
      pulses += int'(tmo_err);
    end
    check("tmo_pulses", pulses, 1);

    // exmem ack lands exactly when the watchdog count reaches the limit.
    bredr_em_req = 1'b1;
    bredr_em_we  = 4'h0;
    bredr_em_adr = 23'h000300;
    repeat (11) tick();
    check("coll_busy", exmem_req, 1'b1);
    exmem_ack  = 1'b1;
    exmem_rdat = 32'hCAFEF00D;
    tick();
    exmem_ack  = 1'b0;
    exmem_rdat = '0;
    check("coll_ack", {bredr_em_ack, tmo_err}, 2'b10);
    check("coll_rdat", bredr_em_rdat, 32'hCAFEF00D);
    check("coll_src_sticky", tmo_src, 1'b1);
    bredr_em_req = 1'b0;
    tick();

    // Reset during BUSY, then the still-pending request is served normally.
    bredr_em_req = 1'b1;
    bredr_em_adr = 23'h000100;
    tick();
    check("rstb_busy", exmem_req, 1'b1);
    bsb_rst = 1'b1;
    tick();
    bsb_rst = 1'b0;
    check("rstb_outputs", {exmem_req, bredr_em_ack, pcm_dma_ack, tmo_err, tmo_src}, 5'b00000);
    check("rstb_adr", exmem_adr, 23'h0);
    mem_txn(1, 32'h0BADF00D, who, rd);
    check("rstb_next_who", who, 0);
    check("rstb_next_rdat", rd, 32'h0BADF00D);
    bredr_em_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
